// File: rtl/imem_loader.sv
// imem_loader: receives a framed instruction image from a word stream and writes
// it into the instruction memory one word per cycle. The frame is a length word,
// then that many instruction words, then a checksum word. The CPU stays in halt
// until a complete image with a matching checksum has been written.
//
// Stream handshake: a word transfers on a rising edge of i_clk where
// i_in_valid & o_in_ready. o_in_ready is decoded only from the registered state.
// It has no combinational dependency on i_in_valid. i_in_valid is ignored while
// o_in_ready is low. The loader can take one word every cycle.
module imem_loader #(
  parameter int DATA_W    = 10,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_word_count,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_LOAD = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Largest image that fits between BASE_ADDR and the top of the address space.
  localparam int unsigned MAX_LEN = (32'd1 << ADDR_W) - 32'(BASE_ADDR);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_len;
  logic [DATA_W-1:0]   r_csum;
  logic [ADDR_W-1:0]   r_word_count;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_start_ok;
  logic                w_len_bad;
  logic                w_last_word;
  logic [DATA_W-1:0]   w_csum_next;

  assign w_accept    = w_in_ready & i_in_valid;
  // start is only honoured when no frame is in progress.
  assign w_start_ok  = i_start & ((r_state == S_IDLE) | (r_state == S_DONE) |
                                  (r_state == S_ERR));
  assign w_len_bad   = (i_in_data == '0) || (32'(i_in_data) > MAX_LEN);
  // The word being accepted now is the last instruction of the image.
  assign w_last_word = ((32'(r_word_count) + 32'd1) == 32'(r_len));
  assign w_csum_next = r_csum + i_in_data;

  // State register; reset always wins over start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode driven by start and accepted stream words.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_accept) w_next = w_len_bad ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        if (w_accept && w_last_word) w_next = S_CSUM;
      end
      S_CSUM: begin
        if (w_accept) w_next = (i_in_data == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded purely from the registered state.
  always_comb begin
    w_in_ready = 1'b0;
    o_busy     = 1'b0;
    o_cpu_hold = 1'b1;
    o_done     = 1'b0;
    o_error    = 1'b0;
    case (r_state)
      S_LEN, S_LOAD, S_CSUM: begin
        w_in_ready = 1'b1;
        o_busy     = 1'b1;
      end
      S_DONE: begin
        o_done     = 1'b1;
        o_cpu_hold = 1'b0;
      end
      S_ERR: begin
        o_error    = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame datapath: length capture, running checksum, word counter and the
  // registered memory write (one cycle after each instruction accept).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len        <= '0;
      r_csum       <= '0;
      r_word_count <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_ok) begin
        r_word_count <= '0;
        r_csum       <= '0;
      end
      case (r_state)
        S_LEN: begin
          if (w_accept) r_len <= i_in_data;
        end
        S_LOAD: begin
          if (w_accept) begin
            r_mem_we     <= 1'b1;
            r_mem_addr   <= ADDR_W'(BASE_ADDR) + r_word_count;
            r_mem_wdata  <= i_in_data;
            r_word_count <= r_word_count + ADDR_W'(1);
            r_csum       <= w_csum_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_word_count = r_word_count;
  assign o_dbg_state  = r_state;

endmodule
